// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: serial FSM state encoding and default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock.
// Result and flags are registered on entry to DONE and held until the next DONE or reset.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | processing one bit per cycle, busy=1
// DONE  | one-cycle done pulse; a new start may be accepted here
module serial_ripple_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic               r_sa;
  logic               r_sb;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_bout;
  logic [WIDTH-1:0]   w_a_nxt;

  assign w_accept = start && (r_state != SHIFT);
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // The minuend register doubles as the result register: each difference bit
  // enters at the MSB as the consumed operand bit leaves at the LSB.
  assign w_a_nxt = {w_d, r_a[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_sa  <= a[WIDTH-1];
      r_sb  <= b[WIDTH-1];
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= w_a_nxt;
      r_b   <= r_b >> 1;
      r_br  <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_a_nxt;
        r_bout <= w_bout;
        r_ovf  <= (r_sa != r_sb) && (w_d != r_sa);
      end
    end
  end

  assign diff     = r_diff;
  assign bout     = r_bout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench: 4-bit instance (directed, sweep, busy-start, mid-op reset) and an 8-bit instance.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  serial_ripple_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .overflow(ovf4)
  );

  serial_ripple_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .overflow(ovf8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sweep_mode = 1'b0;
  int   last_done = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bi,
                                 input int acc);
    exp_t       m;
    logic [4:0] r;
    r      = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    m.diff = r[3:0];
    m.bout = r[4];
    m.ovf  = (a[3] != b[3]) && (r[3] != a[3]);
    m.acc  = acc;
    return m;
  endfunction

  // Scoreboard consumer for the 4-bit instance.
  always @(negedge clk) begin
    if (done4) begin
      if (q.size() == 0) begin
        check("spurious_done", done4, 1'b0);
      end else begin
        e = q.pop_front();
        check("diff", diff4, e.diff);
        check("bout", bout4, e.bout);
        check("overflow", ovf4, e.ovf);
        check("latency", cyc - e.acc, 4);
        check("busy_in_done", busy4, 1'b0);
        if (sweep_mode && last_done >= 0) check("spacing", cyc - last_done, 5);
        last_done = cyc;
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int guard = 0;
    @(negedge clk);
    while (busy4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy4) check("issue_timeout", busy4, 1'b0);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    q.push_back(model(a, b, bi, cyc + 1));
  endtask

  task automatic release_start();
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc8;
    int guard;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_diff4", diff4, 4'h0);
    check("rst_bout4", bout4, 1'b0);
    check("rst_ovf4", ovf4, 1'b0);
    check("rst_diff8", diff8, 8'h00);
    rst = 1'b0;

    // Directed cases, including the boundary values.
    issue(4'd9, 4'd3, 1'b0); release_start(); drain();
    check("hold_diff_9m3", diff4, 4'h6);
    check("hold_ovf_9m3", ovf4, 1'b1);
    issue(4'd3, 4'd9, 1'b0); release_start(); drain();
    issue(4'd0, 4'd0, 1'b1); release_start(); drain();
    issue(4'hF, 4'd0, 1'b1); release_start(); drain();
    issue(4'd6, 4'd6, 1'b0); release_start(); drain();
    repeat (5) @(negedge clk);
    check("hold_idle_diff", diff4, 4'h0);

    // Exhaustive back-to-back sweep with start held high.
    sweep_mode = 1'b1;
    last_done  = -1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      issue(v[8:5], v[4:1], v[0]);
    end
    release_start();
    drain();
    sweep_mode = 1'b0;

    // Start while busy is ignored.
    issue(4'd7, 4'd2, 1'b0);
    release_start();
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    check("busy_start_diff", diff4, 4'h5);

    // Reset in the middle of an operation.
    issue(4'd9, 4'd3, 1'b0);
    release_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check("midrst_busy", busy4, 1'b0);
    check("midrst_done", done4, 1'b0);
    check("midrst_diff", diff4, 4'h0);
    repeat (10) @(negedge clk);
    issue(4'd5, 4'd5, 1'b0); release_start(); drain();

    // Simultaneous reset and start: reset wins.
    @(negedge clk);
    rst = 1'b1; a4 = 4'd2; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    check("rst_vs_start_busy", busy4, 1'b0);
    rst = 1'b0; start4 = 1'b0;
    repeat (8) @(negedge clk);

    // 8-bit instance.
    check("w8_idle", busy8, 1'b0);
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    acc8 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    guard = 0;
    while (!done8 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("w8_done_seen", done8, 1'b1);
    check("w8_latency", cyc - acc8, 8);
    check("w8_diff", diff8, 8'hFF);
    check("w8_bout", bout8, 1'b1);
    check("w8_ovf", ovf8, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("w8_hold", {ovf8, bout8, diff8}, {1'b0, 1'b1, 8'hFF});
    end

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
